// File: rtl/dvp_pixel_capture.sv
// DVP byte-pair capture: assembles 8-bit sensor bytes into RGB565 pixels,
// discards start-up frames, gates capture on frame boundaries and measures
// the incoming image geometry. Everything runs on the sensor pixel clock.
module dvp_pixel_capture #(
  parameter int SKIP_FRAMES = 10,
  parameter bit BYTE_SWAP   = 1'b0,
  parameter int CNT_W       = 12
) (
  input  logic             ov5640_pclk,
  input  logic             rst_n,
  input  logic             ov5640_vsync,
  input  logic             ov5640_href,
  input  logic [7:0]       ov5640_data,
  input  logic             capture_en,
  output logic [15:0]      m_data,
  output logic             m_wr_en,
  output logic             m_sof,
  output logic             m_eol,
  output logic             frame_active,
  output logic [CNT_W-1:0] img_width,
  output logic [CNT_W-1:0] img_height,
  output logic             line_err
);

  typedef enum logic [1:0] {ST_SKIP, ST_IDLE, ST_ACTIVE} state_e;

  localparam int     SKIP_W   = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);
  // With no frames to discard the skip state is never entered.
  localparam state_e RESET_ST = (SKIP_FRAMES == 0) ? ST_IDLE : ST_SKIP;

  state_e             state_q, state_d;
  logic [SKIP_W-1:0]  skip_cnt_q, skip_cnt_d;
  logic               vsync_d1_q, href_d1_q;
  logic               phase_q;
  logic [7:0]         first_q;
  logic [15:0]        m_data_q;
  logic               m_wr_en_q, m_sof_q, m_eol_q;
  logic               sof_pend_q;
  logic [CNT_W-1:0]   pix_cnt_q, line_cnt_q;
  logic [CNT_W-1:0]   img_width_q, img_height_q;
  logic               line_err_q;

  logic               vs_rise, hs_fall, pix_fire, active;
  logic [CNT_W-1:0]   line_cnt_hs;

  assign vs_rise  = ov5640_vsync & ~vsync_d1_q;
  assign hs_fall  = ~ov5640_href & href_d1_q;
  assign pix_fire = ov5640_href & phase_q;
  assign active   = (state_q == ST_ACTIVE);

  // Line count including a line ending this cycle, so a line closed on the
  // same edge as vsync rises is included in the latched height.
  assign line_cnt_hs = (hs_fall && (line_cnt_q != '1)) ? line_cnt_q + CNT_W'(1)
                                                       : line_cnt_q;

  // Frame-gating FSM state register; moves only on vsync rising edges.
  always_ff @(posedge ov5640_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_ST;
      skip_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  // Next-state logic: skip start-up frames, then follow capture_en per frame.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    if (vs_rise) begin
      case (state_q)
        ST_SKIP: begin
          skip_cnt_d = skip_cnt_q + SKIP_W'(1);
          if (skip_cnt_d == SKIP_W'(SKIP_FRAMES)) state_d = ST_IDLE;
        end
        ST_IDLE:   if (capture_en)  state_d = ST_ACTIVE;
        ST_ACTIVE: if (!capture_en) state_d = ST_IDLE;
        default:   state_d = RESET_ST;
      endcase
    end
  end

  // Sync edge detectors, byte phase and pixel assembly.
  always_ff @(posedge ov5640_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1_q <= 1'b0;
      href_d1_q  <= 1'b0;
      phase_q    <= 1'b0;
      first_q    <= '0;
      m_data_q   <= '0;
    end else begin
      vsync_d1_q <= ov5640_vsync;
      href_d1_q  <= ov5640_href;
      phase_q    <= ov5640_href ? ~phase_q : 1'b0;
      if (ov5640_href && !phase_q) first_q <= ov5640_data;
      if (pix_fire) begin
        if (BYTE_SWAP) m_data_q <= {ov5640_data, first_q};
        else           m_data_q <= {first_q, ov5640_data};
      end
    end
  end

  // Output strobes: pixel valid, start-of-frame and end-of-line markers.
  always_ff @(posedge ov5640_pclk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr_en_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_eol_q    <= 1'b0;
      sof_pend_q <= 1'b0;
    end else begin
      m_wr_en_q <= pix_fire & active;
      m_sof_q   <= pix_fire & active & sof_pend_q;
      m_eol_q   <= hs_fall & active;
      if (vs_rise && (state_d == ST_ACTIVE)) sof_pend_q <= 1'b1;
      else if (pix_fire && active)           sof_pend_q <= 1'b0;
    end
  end

  // Geometry measurement and odd-line detection, independent of capture state.
  always_ff @(posedge ov5640_pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      img_width_q  <= '0;
      img_height_q <= '0;
      line_err_q   <= 1'b0;
    end else begin
      if (hs_fall) begin
        img_width_q <= pix_cnt_q;
        pix_cnt_q   <= '0;
      end else if (pix_fire && (pix_cnt_q != '1)) begin
        pix_cnt_q <= pix_cnt_q + CNT_W'(1);
      end
      if (vs_rise) begin
        if (line_cnt_hs != '0) img_height_q <= line_cnt_hs;
        line_cnt_q <= '0;
      end else begin
        line_cnt_q <= line_cnt_hs;
      end
      // A line ending mid-pair drops its trailing byte and flags the error.
      if (hs_fall && phase_q) line_err_q <= 1'b1;
    end
  end

  assign m_data       = m_data_q;
  assign m_wr_en      = m_wr_en_q;
  assign m_sof        = m_sof_q;
  assign m_eol        = m_eol_q;
  assign frame_active = active;
  assign img_width    = img_width_q;
  assign img_height   = img_height_q;
  assign line_err     = line_err_q;

endmodule

// File: doc/dvp_pixel_capture.md
Name: dvp_pixel_capture

Overview:
- Parametrised successor to the OV5640 DVP byte-pair capture stage.
- Runs in the camera pixel-clock domain between the sensor pins and the frame-buffer write FIFO.
- Assembles 8-bit DVP bytes into 16-bit RGB565 pixels and discards a configurable number of start-up frames.
- Also provides: frame-boundary capture gating, start-of-frame and end-of-line markers, measured image width/height, and an odd-byte line error flag.

Parameters:
- SKIP_FRAMES, 10: vsync rising edges discarded after reset before capture may begin (0 = no skip).
- BYTE_SWAP, 0: 0 = first byte of a pair is pixel[15:8]; 1 = first byte is pixel[7:0].
- CNT_W, 12: width of the pixel and line counters and of img_width/img_height.

Ports:
- ov5640_pclk  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ov5640_vsync  in  1  frame sync; rising edge marks frame boundary.
- ov5640_href  in  1  line valid.
- ov5640_data  in  8  DVP data byte.
- capture_en  in  1  capture request; sampled only at vsync rising edge.
- m_data  out  16  assembled pixel.
- m_wr_en  out  1  one-cycle pixel valid.
- m_sof  out  1  high with the first m_wr_en of a captured frame.
- m_eol  out  1  one-cycle pulse, the cycle after href falls in a captured frame.
- frame_active  out  1  current frame is being captured.
- img_width  out  CNT_W  pixels in the last completed line.
- img_height  out  CNT_W  lines in the last completed frame.
- line_err  out  1  sticky; set when a line has an odd byte count.

Behaviour:
- Reset values: all outputs 0; internal registers 0 (including the vsync/href delay registers).
- Edge detection:
  - vs_rise = ov5640_vsync & ~vsync_d1.
  - hs_fall = ~ov5640_href & href_d1.
  - vsync_d1 and href_d1 are registered with reset.
- Byte phase:
  - phase toggles on every pclk while href=1; forced to 0 while href=0.
  - phase=0 byte goes to the "first" half, phase=1 byte to the "second" half, per BYTE_SWAP.
- Pixel output:
  - On the edge where href=1 and phase=1, m_data is registered as {first, second} (or the swapped order).
  - If frame_active, m_wr_en=1 for exactly the next cycle.
  - Latency: pixel visible one pclk after its second byte is sampled.
  - m_data holds its value between pixels.
- State machine, updated only on vs_rise:
  - SKIP (reset state): skip_cnt increments on each vs_rise. When skip_cnt reaches SKIP_FRAMES, go to IDLE on that vs_rise. SKIP_FRAMES=0 leaves reset directly in IDLE.
  - IDLE: on vs_rise with capture_en=1, go to ACTIVE and set frame_active=1.
  - ACTIVE: on vs_rise with capture_en=0, go to IDLE and clear frame_active. Otherwise stay in ACTIVE.
  - capture_en changing mid-frame has no effect until the next vs_rise; frames are never truncated.
- m_sof:
  - A pending flag is set on each vs_rise that leaves the FSM in ACTIVE.
  - m_sof is asserted together with the first m_wr_en after that vs_rise, then the pending flag clears.
- m_eol: pulses on the cycle after hs_fall when frame_active=1.
- Measurement (runs in all states, including SKIP):
  - pix_cnt increments per assembled pixel and saturates at all-ones.
  - On hs_fall: img_width <= pix_cnt, pix_cnt cleared.
  - line_cnt increments on hs_fall and saturates.
  - On vs_rise: if line_cnt != 0, img_height <= line_cnt; line_cnt is cleared either way.
- Odd line:
  - If hs_fall occurs with phase=1, the trailing byte is dropped (no m_wr_en) and line_err is set.
  - line_err clears only on reset.
- Simultaneous hs_fall and vs_rise: both updates apply in the same cycle. The line is counted before img_height is latched, i.e. img_height = line_cnt+1.
- Reset mid-line: all outputs return to 0 immediately. Capture resumes only after SKIP_FRAMES further vs_rise events.

Test Plan:
- Reset, 12 frames of 4 lines × 8 bytes, capture_en=1 → no m_wr_en for frames 1–10. Frame 11 gives 16 m_wr_en pulses; m_sof on the first; 4 m_eol pulses; img_width=4, img_height=4.
- BYTE_SWAP=0, bytes 0xF8,0x1F → m_data=0xF81F, one cycle after 0x1F sampled. BYTE_SWAP=1, same bytes → m_data=0x1FF8.
- Line of 7 bytes (0x01..0x07) → 3 pixels 0x0102, 0x0304, 0x0506; 0x07 dropped; line_err=1 and stays high; img_width=3.
- capture_en dropped mid-frame → current frame completes all pixels; next frame produces no m_wr_en and frame_active=0. Re-asserting capture_en restarts output at the following vs_rise with m_sof.
- SKIP_FRAMES=0 → first vs_rise with capture_en=1 captures immediately. hs_fall coincident with vs_rise on a 3-line frame → img_height=3.
- rst_n pulsed low mid-line during ACTIVE → m_wr_en, m_sof, frame_active, img_width, img_height all 0 asynchronously; skip count restarts.
